// File: rtl/io_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : io_write_arbiter
//  Description : Two-master write arbiter for the output-port register bank.
//                Each master owns a one-entry holding buffer. A round-robin
//                grant drains one buffer per cycle into registered
//                addr/datain. A one-cycle write strobe is issued when the
//                port code is in range; otherwise a one-cycle error flag is
//                raised.
//  Revision    : 1.0  initial release
// ============================================================================
module io_write_arbiter #(
   parameter logic [5:0] BASE_SEL  = 6'b100000,
   parameter int         NUM_PORTS = 3
) (
   input  logic        io_clk,
   input  logic        clrn,
   input  logic        m0_valid,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_data,
   output logic        m0_ready,
   input  logic        m1_valid,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_data,
   output logic        m1_ready,
   output logic [31:0] addr,
   output logic [31:0] datain,
   output logic        write_io_enable,
   output logic        err_pulse,
   output logic        last_grant
);

   // Port-code window, widened by one bit so BASE_SEL+NUM_PORTS-1 cannot wrap.
   localparam logic [6:0] c_FIRST_SEL = {1'b0, BASE_SEL};
   localparam logic [6:0] c_LAST_SEL  = c_FIRST_SEL + 7'(NUM_PORTS) - 7'd1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_GRANT0 = 2'd1,
      ST_GRANT1 = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_next_state;

   logic        r_buf0_full;
   logic [31:0] r_buf0_addr;
   logic [31:0] r_buf0_data;
   logic        r_buf1_full;
   logic [31:0] r_buf1_addr;
   logic [31:0] r_buf1_data;

   logic [31:0] r_addr;
   logic [31:0] r_datain;
   logic        r_wr_en;
   logic        r_err;
   logic        r_last_grant;

   logic        w_prev_grant;
   logic        w_grant0;
   logic        w_grant1;
   logic        w_accept0;
   logic        w_accept1;
   logic [31:0] w_sel_addr;
   logic [31:0] w_sel_data;
   logic [6:0]  w_sel_code;
   logic        w_addr_ok;

   // The grant is decided from registered buffer state, so the buffer being
   // drained on the coming edge is cleared (or refilled with a fresh entry)
   // on that same edge and is never issued twice.
   assign w_grant0  = (w_next_state == ST_GRANT0);
   assign w_grant1  = (w_next_state == ST_GRANT1);

   // Ready depends only on registers: free buffer, or buffer drained this edge.
   assign m0_ready  = ~r_buf0_full | w_grant0;
   assign m1_ready  = ~r_buf1_full | w_grant1;

   assign w_accept0 = m0_valid & m0_ready;
   assign w_accept1 = m1_valid & m1_ready;

   assign w_sel_addr = w_grant1 ? r_buf1_addr : r_buf0_addr;
   assign w_sel_data = w_grant1 ? r_buf1_data : r_buf0_data;
   assign w_sel_code = {1'b0, w_sel_addr[7:2]};
   assign w_addr_ok  = (w_sel_code >= c_FIRST_SEL) && (w_sel_code <= c_LAST_SEL);

   // Next-grant selection: single requester wins, a tie goes to the master
   // that was not granted last (back-to-back grants use the state register,
   // otherwise the remembered last grant).
   always_comb begin
      w_prev_grant = r_last_grant;
      w_next_state = ST_IDLE;
      if (r_state == ST_GRANT0) begin
         w_prev_grant = 1'b0;
      end else if (r_state == ST_GRANT1) begin
         w_prev_grant = 1'b1;
      end
      case ({r_buf1_full, r_buf0_full})
         2'b01:   w_next_state = ST_GRANT0;
         2'b10:   w_next_state = ST_GRANT1;
         2'b11:   w_next_state = w_prev_grant ? ST_GRANT0 : ST_GRANT1;
         default: w_next_state = ST_IDLE;
      endcase
   end

   // State register: records the grant issued on each edge.
   always_ff @(posedge io_clk or negedge clrn) begin
      if (!clrn) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Master 0 holding buffer: a new accept wins over the clear of a drained entry.
   always_ff @(posedge io_clk or negedge clrn) begin
      if (!clrn) begin
         r_buf0_full <= 1'b0;
         r_buf0_addr <= 32'd0;
         r_buf0_data <= 32'd0;
      end else if (w_accept0) begin
         r_buf0_full <= 1'b1;
         r_buf0_addr <= m0_addr;
         r_buf0_data <= m0_data;
      end else if (w_grant0) begin
         r_buf0_full <= 1'b0;
      end
   end

   // Master 1 holding buffer: same policy as master 0.
   always_ff @(posedge io_clk or negedge clrn) begin
      if (!clrn) begin
         r_buf1_full <= 1'b0;
         r_buf1_addr <= 32'd0;
         r_buf1_data <= 32'd0;
      end else if (w_accept1) begin
         r_buf1_full <= 1'b1;
         r_buf1_addr <= m1_addr;
         r_buf1_data <= m1_data;
      end else if (w_grant1) begin
         r_buf1_full <= 1'b0;
      end
   end

   // Bank-side outputs: load on a grant, strobe or flag for exactly one cycle.
   always_ff @(posedge io_clk or negedge clrn) begin
      if (!clrn) begin
         r_addr       <= 32'd0;
         r_datain     <= 32'd0;
         r_wr_en      <= 1'b0;
         r_err        <= 1'b0;
         r_last_grant <= 1'b1;
      end else if (w_grant0 | w_grant1) begin
         r_addr       <= w_sel_addr;
         r_datain     <= w_sel_data;
         r_wr_en      <= w_addr_ok;
         r_err        <= ~w_addr_ok;
         r_last_grant <= w_grant1;
      end else begin
         r_wr_en      <= 1'b0;
         r_err        <= 1'b0;
      end
   end

   assign addr            = r_addr;
   assign datain          = r_datain;
   assign write_io_enable = r_wr_en;
   assign err_pulse       = r_err;
   assign last_grant      = r_last_grant;

endmodule
`default_nettype wire

// File: tb/tb_io_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_io_write_arbiter
//  Description : Self-checking bench for io_write_arbiter. Per-master drivers
//                feed stimulus queues; expected bank writes are queued in
//                arbitration order and popped by a monitor on each strobe.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_io_write_arbiter;

   typedef struct {
      bit          m;
      logic [31:0] a;
      logic [31:0] d;
      bit          err;
      int          lat;
   } exp_t;

   typedef struct {
      logic [31:0] a;
      logic [31:0] d;
   } stim_t;

   typedef struct {
      bit          m;
      logic [31:0] a;
      logic [31:0] d;
      bit          err;
   } vec_t;

   logic        clk = 1'b0;
   logic        clrn = 1'b1;
   logic        m0_valid = 1'b0;
   logic [31:0] m0_addr = 32'd0;
   logic [31:0] m0_data = 32'd0;
   logic        m0_ready;
   logic        m1_valid = 1'b0;
   logic [31:0] m1_addr = 32'd0;
   logic [31:0] m1_data = 32'd0;
   logic        m1_ready;
   logic [31:0] addr;
   logic [31:0] datain;
   logic        write_io_enable;
   logic        err_pulse;
   logic        last_grant;

   int    errors = 0;
   int    checks = 0;
   int    cyc = 0;
   int    run0 = 0;
   int    run1 = 0;
   int    max0 = 0;
   int    max1 = 0;
   exp_t  sb[$];
   stim_t q0[$];
   stim_t q1[$];
   int    acc0[$];
   int    acc1[$];
   exp_t  mon_e;
   int    mon_acc;
   vec_t  tbl[9];

   io_write_arbiter #(
      .BASE_SEL  (6'b100000),
      .NUM_PORTS (3)
   ) dut (
      .io_clk          (clk),
      .clrn            (clrn),
      .m0_valid        (m0_valid),
      .m0_addr         (m0_addr),
      .m0_data         (m0_data),
      .m0_ready        (m0_ready),
      .m1_valid        (m1_valid),
      .m1_addr         (m1_addr),
      .m1_data         (m1_data),
      .m1_ready        (m1_ready),
      .addr            (addr),
      .datain          (datain),
      .write_io_enable (write_io_enable),
      .err_pulse       (err_pulse),
      .last_grant      (last_grant)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic expect_wr(input bit m, input logic [31:0] a, input logic [31:0] d,
                            input bit err, input int lat);
      sb.push_back('{m, a, d, err, lat});
   endtask

   task automatic send(input bit m, input logic [31:0] a, input logic [31:0] d);
      if (m) q1.push_back('{a, d});
      else   q0.push_back('{a, d});
   endtask

   task automatic wait_drain(input string name);
      int n;
      n = 0;
      while ((sb.size() != 0 || q0.size() != 0 || q1.size() != 0) && n < 60) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n >= 60) begin
         errors++;
         $display("FAIL %s drain: actual=%0d pending writes, required=0", name, sb.size());
         sb.delete();
         q0.delete();
         q1.delete();
      end
      repeat (3) @(negedge clk);
   endtask

   // Master 0 driver: present queue head, pop when the edge accepts it.
   initial begin : drv0
      forever begin
         @(negedge clk);
         if (q0.size() != 0) begin
            m0_valid = 1'b1;
            m0_addr  = q0[0].a;
            m0_data  = q0[0].d;
         end else begin
            m0_valid = 1'b0;
         end
         if (m0_valid && m0_ready && clrn) begin
            acc0.push_back(cyc + 1);
            @(posedge clk);
            if (q0.size() != 0) q0.delete(0);
         end
      end
   end

   // Master 1 driver.
   initial begin : drv1
      forever begin
         @(negedge clk);
         if (q1.size() != 0) begin
            m1_valid = 1'b1;
            m1_addr  = q1[0].a;
            m1_data  = q1[0].d;
         end else begin
            m1_valid = 1'b0;
         end
         if (m1_valid && m1_ready && clrn) begin
            acc1.push_back(cyc + 1);
            @(posedge clk);
            if (q1.size() != 0) q1.delete(0);
         end
      end
   end

   // Longest run of cycles each master waits with valid high and ready low.
   always @(negedge clk) begin
      if (m0_valid && !m0_ready) run0 = run0 + 1; else run0 = 0;
      if (m1_valid && !m1_ready) run1 = run1 + 1; else run1 = 0;
      if (run0 > max0) max0 = run0;
      if (run1 > max1) max1 = run1;
   end

   // Scoreboard monitor: every strobe or error flag must match the queue head.
   always @(negedge clk) begin
      if (clrn && (write_io_enable || err_pulse)) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: actual addr=%h wie=%b err=%b, required no activity",
                     addr, write_io_enable, err_pulse);
         end else begin
            mon_e = sb.pop_front();
            check("wr_addr", addr, mon_e.a);
            check("wr_data", datain, mon_e.d);
            check("wie_err", 32'({write_io_enable, err_pulse}), 32'({~mon_e.err, mon_e.err}));
            check("last_grant", 32'(last_grant), 32'(mon_e.m));
            mon_acc = -100;
            if (mon_e.m && acc1.size() != 0) mon_acc = acc1.pop_front();
            else if (!mon_e.m && acc0.size() != 0) mon_acc = acc0.pop_front();
            if (mon_e.lat != 0) check("latency", 32'(cyc), 32'(mon_acc + mon_e.lat));
         end
      end
   end

   initial begin : watchdog
      #300000;
      $display("FAIL watchdog: actual=timeout required=completion");
      $fatal(1, "bench timeout");
   end

   initial begin : main
      tbl[0] = '{1'b0, 32'h0000_0080, 32'h0000_1234, 1'b0};
      tbl[1] = '{1'b1, 32'h0000_008C, 32'h0000_5555, 1'b1};
      tbl[2] = '{1'b1, 32'h0000_0084, 32'hDEAD_BEEF, 1'b0};
      tbl[3] = '{1'b0, 32'h0000_007C, 32'h0000_0011, 1'b1};
      tbl[4] = '{1'b0, 32'hFFFF_FF8B, 32'hCAFE_0001, 1'b0};
      tbl[5] = '{1'b1, 32'h0000_0088, 32'h0000_00BB, 1'b0};
      tbl[6] = '{1'b0, 32'h0000_0090, 32'h0000_0066, 1'b1};
      tbl[7] = '{1'b1, 32'h0000_0081, 32'h1357_9BDF, 1'b0};
      tbl[8] = '{1'b0, 32'h0000_0180, 32'h0000_0042, 1'b0};

      // Reset state while clrn is held low.
      #1 clrn = 1'b0;
      #2;
      check("rst_addr", addr, 32'd0);
      check("rst_datain", datain, 32'd0);
      check("rst_wie", 32'(write_io_enable), 32'd0);
      check("rst_err", 32'(err_pulse), 32'd0);
      check("rst_last_grant", 32'(last_grant), 32'd1);
      check("rst_m0_ready", 32'(m0_ready), 32'd1);
      check("rst_m1_ready", 32'(m1_ready), 32'd1);
      repeat (2) @(posedge clk);
      #2 clrn = 1'b1;

      // Single-master writes across in-range and out-of-range port codes.
      for (int i = 0; i < 9; i++) begin
         expect_wr(tbl[i].m, tbl[i].a, tbl[i].d, tbl[i].err, 1);
         send(tbl[i].m, tbl[i].a, tbl[i].d);
         wait_drain("table");
         check("ready_after", 32'(tbl[i].m ? m1_ready : m0_ready), 32'd1);
      end

      // Reset between accept and grant discards the pending write.
      send(1'b0, 32'h0000_0080, 32'h0000_0077);
      begin
         int n;
         n = 0;
         while (q0.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
         end
      end
      #1 clrn = 1'b0;
      #1 check("ready_in_reset", 32'(m0_ready), 32'd1);
      #1 clrn = 1'b1;
      acc0.delete();
      repeat (5) @(negedge clk);
      check("post_rst_addr", addr, 32'd0);
      check("post_rst_datain", datain, 32'd0);
      check("post_rst_last_grant", 32'(last_grant), 32'd1);

      // Simultaneous requests: master 0 wins the first tie, then master 1.
      expect_wr(1'b0, 32'h0000_0084, 32'h0000_000A, 1'b0, 1);
      expect_wr(1'b1, 32'h0000_0088, 32'h0000_000B, 1'b0, 2);
      send(1'b0, 32'h0000_0084, 32'h0000_000A);
      send(1'b1, 32'h0000_0088, 32'h0000_000B);
      wait_drain("tie");
      check("tie_last_grant", 32'(last_grant), 32'd1);

      // Both masters streaming: strict alternation, one strobe per cycle.
      max0 = 0;
      max1 = 0;
      for (int i = 0; i < 4; i++) begin
         expect_wr(1'b0, 32'h80 + 32'(4 * (i % 3)), 32'h100 + 32'(i), 1'b0, (i == 0) ? 1 : 2);
         expect_wr(1'b1, 32'h84 + 32'(4 * (i % 2)), 32'h200 + 32'(i), 1'b0, 2);
         send(1'b0, 32'h80 + 32'(4 * (i % 3)), 32'h100 + 32'(i));
         send(1'b1, 32'h84 + 32'(4 * (i % 2)), 32'h200 + 32'(i));
      end
      wait_drain("stream2");
      check("stream2_m0_stall_le1", 32'(max0 <= 1), 32'd1);
      check("stream2_m1_stall_le1", 32'(max1 <= 1), 32'd1);

      // Single master streaming alone: back-to-back strobes, ready never drops.
      max0 = 0;
      for (int i = 0; i < 3; i++) begin
         expect_wr(1'b0, 32'h80 + 32'(4 * i), 32'hA0 + 32'(i), 1'b0, 1);
         send(1'b0, 32'h80 + 32'(4 * i), 32'hA0 + 32'(i));
      end
      wait_drain("stream1");
      check("stream1_m0_stall", 32'(max0), 32'd0);
      check("idle_wie", 32'(write_io_enable), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/io_write_arbiter.md
IO_WRITE_ARBITER -- requirements
Module: io_write_arbiter

Interface
REQ-001 Parameter BASE_SEL, default 6'b100000: addr[7:2] code of output port 0.
REQ-002 Parameter NUM_PORTS, default 3: count of consecutive valid port codes starting at BASE_SEL.
REQ-003 io_clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 clrn  input  1  reset; asynchronous, active-low.
REQ-005 m0_valid  input  1  master 0 (CPU store path) write request.
REQ-006 m0_addr  input  32  master 0 byte address.
REQ-007 m0_data  input  32  master 0 write data.
REQ-008 m0_ready  output  1  master 0 request accepted this edge when high with m0_valid.
REQ-009 m1_valid, m1_addr, m1_data, m1_ready: master 1 (debug/loader), with the same widths and meanings as master 0.
REQ-010 addr  output  32  registered address to the output-port register bank.
REQ-011 datain  output  32  registered write data to the output-port register bank.
REQ-012 write_io_enable  output  1  registered one-cycle write strobe to the bank.
REQ-013 err_pulse  output  1  one-cycle flag: a granted request was dropped for an out-of-range address.
REQ-014 last_grant  output  1  index of the most recently granted master.

Function
REQ-015 Handshake: a transfer occurs on a rising edge where mN_valid=1 and mN_ready=1; masters shall hold addr/data stable while valid and not ready.
REQ-016 Each master has a one-entry holding buffer (addr, data, full bit); an accepted transfer loads it.
REQ-017 mN_ready = ~bufN_full | grantN_now; it is a function of registered state only, with no path from mN_valid.
REQ-018 FSM states: IDLE (no buffer full), GRANT0, GRANT1; the state register holds the grant for the current cycle.
REQ-019 Next grant: only buf0 full -> GRANT0; only buf1 full -> GRANT1; both full -> the master != last_grant (round robin); neither full -> IDLE.
REQ-020 The buffer fill/clear logic shall exclude the entry being granted in the current cycle from the full test, so that a master is never granted twice for one entry.
REQ-021 At the grant edge: the granted buffer clears, unless it is refilled on the same edge; last_grant updates; addr and datain load from the granted buffer.
REQ-022 Address check at grant: valid iff BASE_SEL <= addr[7:2] <= BASE_SEL+NUM_PORTS-1, compared as unsigned 6-bit values; addr[1:0] and addr[31:8] are ignored.
REQ-023 Valid grant -> write_io_enable=1 for exactly the following cycle; invalid -> write_io_enable=0 and err_pulse=1 for that cycle.
REQ-024 Latency: accepted at edge N -> granted at edge N+1 -> write_io_enable high in cycle N+1..N+2 -> bank captures at edge N+2.
REQ-025 Throughput: one grant per cycle sustained; a single master streaming back-to-back achieves 1 write/cycle.
REQ-026 Fairness: with both masters continuously valid, grants alternate 0,1,0,1; no master waits more than 2 grant slots.
REQ-027 Simultaneous accept and grant on the same master at one edge: the buffer holds the new entry, and the old entry is issued.
REQ-028 addr and datain retain their last values when no grant occurs; write_io_enable and err_pulse are 0 in every non-grant cycle.

Reset
REQ-029 clrn low asynchronously forces: both buffers empty, state IDLE, addr=0, datain=0, write_io_enable=0, err_pulse=0, last_grant=1 (master 0 wins the first tie).
REQ-030 Reset mid-operation discards pending buffered requests; no write strobe is generated for them after release.
REQ-031 While clrn is low, mN_ready=1; no transfer is recorded while clrn is low.
REQ-032 The first edge with clrn high behaves as a normal edge; no synchronizer stage is implied.

Verification
REQ-033 m0 writes addr 0x80, data 0x1234 -> edge N+2: addr=0x80, datain=0x1234, write_io_enable=1 for one cycle, err_pulse=0.
REQ-034 m0 and m1 valid on the same edge, m0 addr 0x84 / data 0xA, m1 addr 0x88 / data 0xB -> strobe to 0x84 data 0xA first, then 0x88 data 0xB on the next cycle, then last_grant=1.
REQ-035 Both masters stream 4 writes each continuously -> 8 consecutive strobes in the order 0,1,0,1,...; ready never drops for more than 1 cycle per master.
REQ-036 m1 writes addr 0x8C (addr[7:2]=0x23) -> no strobe, err_pulse=1 for one cycle, m1_ready returns high.
REQ-037 m0 accepted, then clrn pulsed low before the grant edge -> after release: no strobe, addr=0, last_grant=1.
REQ-038 m0 streams 0x80, 0x84, 0x88 back-to-back alone -> 3 strobes on consecutive cycles; m0_ready is held high throughout.
